// File: rtl/mult_booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encoding and
// the default operand width.
package mult_booth_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier. One add/subtract/shift step per
// clock; a WIDTH x WIDTH signed multiply takes WIDTH steps in RUN plus one
// DONE cycle that publishes {hi,lo}.
module mult_booth
   import mult_booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   state_t           state;
   state_t           state_next;

   // Working registers: multiplicand, partial-product accumulator (one
   // guard bit), multiplier/low product, Booth history bit, step counter.
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   acc_sum;
   logic [WIDTH:0]   acc_next;
   logic [WIDTH-1:0] q_next;
   logic             q_1_next;

   // One Booth step: add/subtract the sign-extended multiplicand, then
   // arithmetic-shift {acc,q,q_1} right by one. The extra accumulator bit
   // keeps -(-2^(WIDTH-1)) representable.
   always_comb begin
      m_ext = {m_reg[WIDTH-1], m_reg};
      case ({q[0], q_1})
         2'b01:   acc_sum = acc + m_ext;
         2'b10:   acc_sum = acc - m_ext;
         default: acc_sum = acc;
      endcase
      acc_next = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      q_next   = {acc_sum[0], q[WIDTH-1:1]};
      q_1_next = q[0];
   end

   // Next-state logic and the busy flag.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (count == CNT_LAST) state_next = ST_DONE;
         end
         ST_DONE: begin
            busy       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Operand capture on accept, one Booth step per RUN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_reg <= '0;
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  m_reg <= a;
                  acc   <= '0;
                  q     <= b;
                  q_1   <= 1'b0;
                  count <= CNT_INIT;
               end
            end
            ST_RUN: begin
               acc   <= acc_next;
               q     <= q_next;
               q_1   <= q_1_next;
               count <= count - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result publication: hi/lo only change in DONE, so they hold the
   // previous result throughout a new RUN; done is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == ST_DONE);
         if (state == ST_DONE) begin
            hi <= acc[WIDTH-1:0];
            lo <= q;
         end
      end
   end

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_mult_booth;

   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 1;

   typedef struct {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      int               due;
   } exp_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
   } vec_t;

   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   mult_booth #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t             sbq[$];
   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] hold_hi = '0;
   logic [WIDTH-1:0] hold_lo = '0;
   logic             rst_prev = 1'b0;
   logic             done_prev = 1'b0;
   int               busy_run = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: reset state, hold-during-run, result/latency/busy on done,
   // unexpected or missing done pulses.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            chk("reset_hi",   64'(hi),   64'd0);
            chk("reset_lo",   64'(lo),   64'd0);
            chk("reset_busy", 64'(busy), 64'd0);
            chk("reset_done", 64'(done), 64'd0);
            hold_hi  = '0;
            hold_lo  = '0;
            busy_run = 0;
         end else begin
            if (busy) begin
               busy_run++;
               chk("hold_hi", 64'(hi), 64'(hold_hi));
               chk("hold_lo", 64'(lo), 64'(hold_lo));
            end
            if (done) begin
               chk("done_width", 64'(done_prev), 64'd0);
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h with no pending op (cycle %0d)", hi, lo, cyc);
               end else begin
                  e = sbq.pop_front();
                  chk("hi",          64'(hi),       64'(e.hi));
                  chk("lo",          64'(lo),       64'(e.lo));
                  chk("latency",     64'(cyc),      64'(e.due));
                  chk("busy_cycles", 64'(busy_run), 64'(LAT));
                  hold_hi = e.hi;
                  hold_lo = e.lo;
               end
               busy_run = 0;
            end
            if (sbq.size() > 0 && cyc > sbq[0].due + 4) begin
               checks++;
               errors++;
               $display("FAIL done_timeout: no done by cycle %0d, expected at %0d", cyc, sbq[0].due);
               void'(sbq.pop_front());
            end
         end
         rst_prev  = reset;
         done_prev = done;
      end
   end

   // Drive a start pulse (called just after a rising edge); optionally
   // record the expected result and the cycle done must appear in.
   task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                        input bit push);
      exp_t e;
      start = 1'b1;
      a     = va;
      b     = vb;
      @(posedge clk);
      #1;
      if (push) begin
         e.hi  = eh;
         e.lo  = el;
         e.due = cyc + LAT;
         sbq.push_back(e);
      end
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < LAT + 8; i++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
   endtask

   task automatic run(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
      issue(va, vb, eh, el, 1'b1);
      wait_done();
   endtask

   vec_t vecs[8];

   initial begin
      logic signed [63:0] pa;
      logic signed [63:0] pb;
      logic signed [63:0] p;
      logic [WIDTH-1:0]   ra;
      logic [WIDTH-1:0]   rb;

      vecs[0] = {32'd3,         32'd5,         32'h00000000, 32'h0000000F};
      vecs[1] = {32'd7,         32'hFFFFFFFD,  32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2] = {32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001};
      vecs[3] = {32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
      vecs[4] = {32'h80000000,  32'd1,         32'hFFFFFFFF, 32'h80000000};
      vecs[5] = {32'd0,         32'd0,         32'h00000000, 32'h00000000};
      vecs[6] = {32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 32'h00000001};
      vecs[7] = {32'h80000000,  32'h7FFFFFFF,  32'hC0000000, 32'h80000000};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // directed products
      for (int i = 0; i < 8; i++) run(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

      // start re-pulsed mid-run is ignored; back-to-back start after done accepted
      issue(32'd2, 32'd3, 32'h0, 32'h6, 1'b1);
      repeat (9) begin @(posedge clk); #1; end
      start = 1'b1;
      a     = 32'd9;
      b     = 32'd9;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      run(32'd5, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2);

      // reset mid-run aborts; no done, result never published
      repeat (2) begin @(posedge clk); #1; end
      issue(32'd4, 32'd4, 32'h0, 32'h0, 1'b0);
      repeat (14) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (LAT + 10) begin @(posedge clk); #1; end
      run(32'd2, 32'd2, 32'h0, 32'h4);

      // random signed pairs against a 64-bit reference product
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) ra = ra >> $urandom_range(31, 1);
         if (i % 4 == 2) rb = {WIDTH{rb[0]}} ^ (rb >> 24);
         pa = $signed(ra);
         pb = $signed(rb);
         p  = pa * pb;
         run(ra, rb, p[63:32], p[31:0]);
      end

      repeat (10) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand, two's complement; captured when start is accepted.
REQ-006 b  input  WIDTH  multiplier, two's complement; captured when start is accepted.
REQ-007 hi  output  WIDTH  upper half of the signed 2*WIDTH product; feeds the HI select-mux input.
REQ-008 lo  output  WIDTH  lower half of the signed 2*WIDTH product; feeds the LO select-mux input.
REQ-009 busy  output  1  high while an operation is in RUN or DONE.
REQ-010 done  output  1  one-cycle pulse; hi/lo are valid from this cycle on.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 Accept: IDLE with start=1 at an edge SHALL capture M=a, load A=0 (WIDTH+1 bits), Q=b, Q_1=0 and count=WIDTH, and enter RUN.
REQ-013 RUN step, on bits {Q[0],Q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged. Then arithmetic-shift-right {A,Q,Q_1} by one and decrement count.
REQ-014 M SHALL be sign-extended to WIDTH+1 bits so that M=-2^(WIDTH-1) cannot overflow A.
REQ-015 RUN SHALL perform exactly WIDTH steps and then enter DONE.
REQ-016 DONE SHALL register hi=A[WIDTH-1:0] and lo=Q, assert done for exactly that one cycle, and return to IDLE on the next edge.
REQ-017 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH+1 (33 edges for WIDTH=32).
REQ-018 hi/lo SHALL hold their last result until the next DONE; they SHALL NOT change during RUN.
REQ-019 start SHALL be ignored in RUN and DONE; the next operation is accepted only from IDLE.
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 a/b changes after acceptance SHALL NOT affect the result in progress.
REQ-022 Zero operands SHALL still take the full latency; there is no early termination.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, hi=0, lo=0, done=0, busy=0, A=0, Q=0, Q_1=0, count=0.
REQ-024 reset SHALL override start and any in-progress RUN/DONE; the aborted result SHALL never appear on hi/lo.
REQ-025 After reset deasserts, the first edge with start=1 SHALL begin a fresh operation.

Structure
REQ-026 A shared processor package SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 The block SHALL be a single module with no sub-modules; the add/subtract/shift datapath is inline.

Verification
REQ-028 a=3, b=5, start pulse -> done after 33 edges; hi=0x00000000, lo=0x0000000F; busy high for 33 cycles.
REQ-029 a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; a=b=0xFFFFFFFF -> hi=0, lo=0x00000001.
REQ-030 a=b=0x80000000 -> hi=0x40000000, lo=0x00000000 (checks the REQ-014 overflow guard); a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-031 Start 2*3, re-pulse start with a=9, b=9 at edge 10 -> ignored; done at edge 33 with lo=0x00000006; a new start one cycle after done is accepted.
REQ-032 Start 4*4, assert reset at edge 15 -> hi=lo=0, busy=0, no done pulse; a new 2*2 then gives lo=0x00000004.
REQ-033 Random signed pairs (at least 1000) -> {hi,lo} equals the 64-bit signed reference product; done is exactly one cycle wide each time.
